// File: rtl/cache_lookup_ctrl.sv
// Direct-mapped cache lookup/refill controller.
// Owns the line tag store and valid bits; refills misses from memory.
module cache_lookup_ctrl #(
  parameter int INDEX_LENGTH  = 4,
  parameter int TAG_LENGTH    = 22,
  parameter int OFFSET_LENGTH = 6,
  parameter int ADDR_LENGTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_LENGTH-1:0]  req_addr_i,
  input  logic                    flush_i,
  output logic                    resp_valid_o,
  output logic                    resp_hit_o,
  output logic [INDEX_LENGTH-1:0] resp_index_o,
  output logic                    mem_req_o,
  output logic [ADDR_LENGTH-1:0]  mem_addr_o,
  input  logic                    mem_ack_i
);

  localparam int LINES = 2**INDEX_LENGTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [TAG_LENGTH-1:0]   tag_q, tag_d;
  logic [INDEX_LENGTH-1:0] idx_q, idx_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_hit_q, resp_hit_d;
  logic [INDEX_LENGTH-1:0] resp_index_q, resp_index_d;
  logic                    mem_req_q, mem_req_d;
  logic [ADDR_LENGTH-1:0]  mem_addr_q, mem_addr_d;

  logic [TAG_LENGTH-1:0]   tag_mem [LINES];
  logic                    tag_we;
  logic                    hit;

  // Offset bits only select a byte within the line.
  logic unused_offset;
  assign unused_offset = ^req_addr_i[OFFSET_LENGTH-1:0];

  assign hit = valid_q[idx_q] && (tag_mem[idx_q] == tag_q);

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_index_d = resp_index_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    tag_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          valid_d = '0;
        end else if (req_valid_i) begin
          tag_d   = req_addr_i[ADDR_LENGTH-1 -: TAG_LENGTH];
          idx_d   = req_addr_i[OFFSET_LENGTH +: INDEX_LENGTH];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_index_d = idx_q;
        end else begin
          state_d    = S_REFILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {tag_q, idx_q, {OFFSET_LENGTH{1'b0}}};
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          tag_we         = 1'b1;
          valid_d[idx_q] = 1'b1;
          mem_req_d      = 1'b0;
          state_d        = S_RESP;
          resp_valid_d   = 1'b1;
          resp_hit_d     = 1'b0;
          resp_index_d   = idx_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      idx_q        <= '0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_index_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_index_q <= resp_index_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Tag store is not reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (tag_we && !rst) begin
      tag_mem[idx_q] <= tag_q;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE) && !flush_i;
  assign resp_valid_o = resp_valid_q;
  assign resp_hit_o   = resp_hit_q;
  assign resp_index_o = resp_index_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;

endmodule
